// File: rtl/count_sequencer.sv
// count_sequencer: start/stop/pause sequencing of a WIDTH-bit up-counter with
// terminal-count detection, one-shot or auto-reload modes and a one-cycle
// done pulse. All outputs are registered.
//
// Optional feature: define COUNT_SEQ_PRESCALE_EN to add the `prescale` port
// and a PW-bit tick divider (tick every prescale+1 RUN cycles). Without it
// every RUN cycle is a tick.
module count_sequencer #(
  parameter int WIDTH = 4,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] term,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PW-1:0]    prescale,
`endif
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A zero-width prescaler makes no sense; this block only exists so PW is
  // referenced in builds without the prescaler.
  if (PW < 1) begin : g_pw_invalid
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PW-1:0]    presc_q, presc_d;

  // Tick when the divider reaches the live prescale value. If prescale is
  // lowered below the current count, the counter wraps before matching.
  assign tick = (presc_q == prescale);
`else
  assign tick = 1'b1;
`endif

  // Next-state, count, latch and output computation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d = state_q;
    q_d     = q_q;
    term_d  = term_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
    presc_d = presc_q;
`endif

    if (stop) begin
      // stop beats everything, including a terminal edge: no done pulse.
      state_d = ST_IDLE;
      q_d     = '0;
`ifdef COUNT_SEQ_PRESCALE_EN
      presc_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            q_d     = '0;
            term_d  = term;
            mode_d  = mode;
`ifdef COUNT_SEQ_PRESCALE_EN
            presc_d = '0;
`endif
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (pause) begin
            // Hold count and divider; a due tick is simply deferred.
            state_d = ST_PAUSE;
          end else begin
            // Leaving PAUSE behaves exactly like a RUN cycle, so a pause of
            // k cycles delays everything by exactly k cycles.
            state_d = ST_RUN;
            if (tick) begin
`ifdef COUNT_SEQ_PRESCALE_EN
              presc_d = '0;
`endif
              if (q_q != term_q) begin
                q_d = q_q + WIDTH'(1);
              end else begin
                done_d = 1'b1;
                if (mode_q) begin
                  q_d = '0;
                end else begin
                  state_d = ST_DONE;
                end
              end
            end else begin
`ifdef COUNT_SEQ_PRESCALE_EN
              presc_d = presc_q + PW'(1);
`endif
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      term_q  <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      q_q     <= q_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef COUNT_SEQ_PRESCALE_EN
  // Prescale divider register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`endif

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed, table-driven bench for count_sequencer (WIDTH=4). Prescaler
// scenarios are compiled in only when COUNT_SEQ_PRESCALE_EN is defined.
module tb_count_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic       mode;
  logic [3:0] term;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [3:0] prescale;
`endif
  logic [3:0] q;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  count_sequencer #(.WIDTH(4), .PW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .term     (term),
`ifdef COUNT_SEQ_PRESCALE_EN
    .prescale (prescale),
`endif
    .q        (q),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       pause;
    logic       mode;
    logic [3:0] term;
    logic [3:0] exp_q;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] eq, input logic eb, input logic ed);
    check({name, ".q"},    32'(q),    32'(eq));
    check({name, ".busy"}, 32'(busy), 32'(eb));
    check({name, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic drive(input logic s, input logic sp, input logic p, input logic m, input logic [3:0] t);
    start = s;
    stop  = sp;
    pause = p;
    mode  = m;
    term  = t;
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic sp, input logic p, input logic m,
                              input logic [3:0] t, input logic [3:0] eq, input logic eb,
                              input logic ed);
    vec_t v;
    v.start = s; v.stop = sp; v.pause = p; v.mode = m; v.term = t;
    v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

`ifdef COUNT_SEQ_PRESCALE_EN
  // Start a one-shot term=3 run with prescale=2 and return the number of edges
  // after the start edge until done is seen (-1 on timeout). pause_at>0 holds
  // pause high for the 5 edges starting at that edge.
  task automatic measure_done(input int pause_at, output int edges);
    edges = -1;
    prescale = 4'd2;
    drive(1, 0, 0, 0, 4'd3);
    step();
    drive(0, 0, 0, 0, 4'd3);
    for (int e = 1; e <= 40; e++) begin
      pause = (pause_at > 0) && (e >= pause_at) && (e < pause_at + 5);
      step();
      if (done) begin
        edges = e;
        break;
      end
    end
    drive(0, 1, 0, 0, 4'd0);
    step();
    stop = 1'b0;
    prescale = 4'd0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 4'd0);
`ifdef COUNT_SEQ_PRESCALE_EN
    prescale = 4'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // IDLE: pause ignored.
    tbl.push_back(mk(0,0,1,0,4'd5, 4'd0,0,0));
    // One-shot term=5; term/mode changes after start must not matter.
    tbl.push_back(mk(1,0,0,0,4'd5, 4'd0,1,0));
    tbl.push_back(mk(0,0,0,1,4'd9, 4'd1,1,0));
    tbl.push_back(mk(0,0,0,1,4'd9, 4'd2,1,0));
    tbl.push_back(mk(0,0,0,0,4'd0, 4'd3,1,0));
    tbl.push_back(mk(0,0,0,0,4'd0, 4'd4,1,0));
    tbl.push_back(mk(0,0,0,0,4'd0, 4'd5,1,0));
    tbl.push_back(mk(0,0,0,0,4'd0, 4'd5,0,1));
    tbl.push_back(mk(0,0,1,0,4'd0, 4'd5,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0, 4'd5,0,0));
    // Restart from DONE in reload mode, term=2: 9 ticks.
    tbl.push_back(mk(1,0,0,1,4'd2, 4'd0,1,0));
    tbl.push_back(mk(0,0,0,0,4'd2, 4'd1,1,0));
    tbl.push_back(mk(0,0,0,0,4'd2, 4'd2,1,0));
    tbl.push_back(mk(0,0,0,0,4'd2, 4'd0,1,1));
    tbl.push_back(mk(0,0,0,0,4'd2, 4'd1,1,0));
    tbl.push_back(mk(0,0,0,0,4'd2, 4'd2,1,0));
    tbl.push_back(mk(0,0,0,0,4'd2, 4'd0,1,1));
    tbl.push_back(mk(0,0,0,0,4'd2, 4'd1,1,0));
    tbl.push_back(mk(0,0,0,0,4'd2, 4'd2,1,0));
    tbl.push_back(mk(0,0,0,0,4'd2, 4'd0,1,1));
    // start in RUN ignored, then stop.
    tbl.push_back(mk(1,0,0,0,4'd7, 4'd1,1,0));
    tbl.push_back(mk(0,1,0,0,4'd0, 4'd0,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0, 4'd0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].pause, tbl[i].mode, tbl[i].term);
      step();
      check_outs($sformatf("vec%0d", i), tbl[i].exp_q, tbl[i].exp_busy, tbl[i].exp_done);
    end

    // Pause at q=3 for 4 cycles (term=7), resume, then stop+start at q=6.
    drive(1, 0, 0, 0, 4'd7);
    step();
    check_outs("pz_start", 4'd0, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    check_outs("pz_q3", 4'd3, 1'b1, 1'b0);
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_outs($sformatf("pz_hold%0d", k), 4'd3, 1'b1, 1'b0);
    end
    pause = 1'b0;
    step();
    check_outs("pz_resume", 4'd4, 1'b1, 1'b0);
    step();
    step();
    check_outs("pz_q6", 4'd6, 1'b1, 1'b0);
    drive(1, 1, 0, 0, 4'd7);
    step();
    check_outs("stop_start", 4'd0, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 4'd7);
    step();
    check_outs("stop_idle", 4'd0, 1'b0, 1'b0);

    // stop on the edge that would be terminal: no done.
    drive(1, 0, 0, 0, 4'd1);
    step();
    start = 1'b0;
    step();
    check_outs("st_q1", 4'd1, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    check_outs("st_term", 4'd0, 1'b0, 1'b0);
    stop = 1'b0;
    step();
    check_outs("st_after", 4'd0, 1'b0, 1'b0);

    // Async reset mid-count at q=2.
    drive(1, 0, 0, 0, 4'd7);
    step();
    start = 1'b0;
    step();
    step();
    check_outs("ar_q2", 4'd2, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_outs("ar_async", 4'd0, 1'b0, 1'b0);
    step();
    check_outs("ar_held", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    check_outs("ar_idle", 4'd0, 1'b0, 1'b0);

    // term=0 reload: done every cycle, q stays 0; term change ignored.
    drive(1, 0, 0, 1, 4'd0);
    step();
    check_outs("t0_start", 4'd0, 1'b1, 1'b0);
    start = 1'b0;
    step();
    check_outs("t0_a", 4'd0, 1'b1, 1'b1);
    term = 4'd9;
    step();
    check_outs("t0_b", 4'd0, 1'b1, 1'b1);
    step();
    check_outs("t0_c", 4'd0, 1'b1, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_outs("t0_async", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    // New start picks up term=9 one-shot.
    drive(1, 0, 0, 0, 4'd9);
    step();
    check_outs("t9_start", 4'd0, 1'b1, 1'b0);
    start = 1'b0;
    step();
    check_outs("t9_q1", 4'd1, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;

`ifdef COUNT_SEQ_PRESCALE_EN
    begin
      int edges;
      measure_done(0, edges);
      check("presc_done_edges", 32'(edges), 32'd12);
      measure_done(5, edges);
      check("presc_pause_edges", 32'(edges), 32'd17);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Control block that sequences a WIDTH-bit up-counter: start/stop/pause command handling, terminal-count detection, one-shot or auto-reload modes, and a one-cycle `done` pulse. It owns the count register and its enable/clear sequencing, so counter datapaths in the design are driven from a single controlled source instead of free-running on a clock. All state updates on the rising edge of `clk`.

## Interface

Parameters:
- `WIDTH`, 4: count and terminal width in bits.
- `PW`, 4: prescale width in bits; used only with `COUNT_SEQ_PRESCALE_EN`.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin counting from 0; honoured in IDLE and DONE only.
- `stop`  input  1  abort to IDLE and clear count; honoured in every state.
- `pause`  input  1  level; while high in RUN/PAUSE the count holds.
- `mode`  input  1  0 = one-shot, 1 = auto-reload; latched at start.
- `term`  input  WIDTH  terminal value; latched at start.
- `prescale`  input  PW  tick divider, tick every `prescale+1` cycles; present only with `COUNT_SEQ_PRESCALE_EN`.
- `q`  output  WIDTH  current count.
- `busy`  output  1  high in RUN and PAUSE.
- `done`  output  1  one-cycle pulse per terminal event.

## Operation

- States: IDLE, RUN, PAUSE, DONE. Reset (`reset`=0, asynchronous) gives IDLE with `q`=0, `busy`=0, `done`=0, latched `term_r`=0, `mode_r`=0, and prescale counter at 0.
- Command priority: `stop` > `start` > `pause`.
- IDLE:
  - `start`=1 moves to RUN, latches `term_r`/`mode_r`, and keeps `q`=0.
  - `pause` is ignored.
- RUN, on each tick:
  - If `q` != `term_r`, `q` <= `q`+1.
  - If `q` == `term_r`, this is the terminal event and `done` <= 1.
  - One-shot: go to DONE and hold `q`=`term_r`.
  - Reload: `q` <= 0 and stay in RUN.
- RUN with `pause`=1 goes to PAUSE without advancing `q` on that edge, even if a tick was due. PAUSE holds `q` and the prescale counter. PAUSE with `pause`=0 returns to RUN.
- DONE:
  - `busy`=0 and `q` holds `term_r`.
  - `start` restarts: `q` <= 0, new latch, go to RUN.
  - `stop` goes to IDLE with `q` <= 0.
- `stop` in any state: IDLE, `q` <= 0, prescale counter <= 0, and no `done` pulse, including on an edge that would otherwise be terminal.
- `start` in RUN/PAUSE is ignored. Changes to `term`/`mode` after start have no effect until the next start.
- `term`=0: every tick is terminal. In reload mode `done` pulses on every tick and `q` stays 0.
- Count arithmetic is modulo 2^WIDTH. `q` never exceeds `term_r`, so no wrap occurs in normal operation.

## Timing

- All outputs are registered, with no combinational input-to-output paths.
- `start` sampled high at edge N: RUN from edge N. Without the prescaler, the first tick (and increment) is at edge N+1.
- One-shot example, `term`=3: `q`=1,2,3 after edges N+1..N+3. The terminal event is at edge N+4, so `done`=1 for the cycle after N+4, with DONE from N+4.
- Reload period is `term_r`+1 ticks, with one `done` per period. `done` is never high for two consecutive cycles unless `term_r`=0 with a tick every cycle.
- `busy` rises on the same edge as the IDLE/DONE→RUN transition and falls on the edge that enters DONE or IDLE.
- `reset` asserting mid-count clears all outputs immediately (asynchronously). Deassertion is synchronous to `clk`, and the block resumes in IDLE.

## Configuration

- `COUNT_SEQ_PRESCALE_EN` defined:
  - `prescale` port exists, and a PW-bit prescale counter generates a tick when it equals `prescale`, then clears.
  - The prescale counter clears on entry to RUN, holds in PAUSE, and clears on stop.
  - `prescale`=0 gives a tick every cycle.
  - `prescale` is sampled live, not latched.
- `COUNT_SEQ_PRESCALE_EN` not defined: no `prescale` port and no prescale counter; every RUN cycle is a tick.

## Test plan

- Reset values: assert `reset`=0 mid-RUN with `q`=2 → `q`=0, `busy`=0, and `done`=0 immediately, without waiting for a clock edge. Release `reset` → IDLE, and `q` stays 0 until `start`.
- One-shot, `term`=5, `mode`=0, start at edge N → `q` steps 1..5 over N+1..N+5, one `done` pulse after N+6, DONE holds `q`=5, `busy`=0.
- Reload, `term`=2, `mode`=1, 9 ticks → `q` sequence 1,2,0,1,2,0,1,2,0 and exactly 3 `done` pulses, each one cycle wide.
- `pause` high for 4 cycles at `q`=3 (`term`=7) → `q` stays 3 and `busy`=1; after release the count resumes with 4 on the next tick. Assert `stop` and `start` together at `q`=6 → IDLE, `q`=0, no `done`.
- `term`=0, `mode`=1 → `done` high every cycle and `q`=0. Change `term` to 9 mid-run → no effect until the next `start`.
- With `COUNT_SEQ_PRESCALE_EN`, `prescale`=2, `term`=3, one-shot → increments every 3rd cycle and `done` 12 cycles after start. Pause for 5 cycles mid-interval → `done` is delayed by exactly 5 cycles.
